// File: rtl/pipe_ifid_queue.sv
// IF/ID decoupling queue: a DEPTH-entry FIFO of {pc4, inst} pairs between fetch and decode.
// Optional PIPE_IFID_QUEUE_BYPASS_EN lets an entry reach decode in the same cycle while the queue is empty.
module pipe_ifid_queue #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [DATA_W-1:0]          in_pc4,
    input  logic [DATA_W-1:0]          in_inst,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [DATA_W-1:0]          out_pc4,
    output logic [DATA_W-1:0]          out_inst,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    logic [DATA_W-1:0] pc4_mem_q  [DEPTH];
    logic [DATA_W-1:0] inst_mem_q [DEPTH];
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              empty, push, pop, wr_en, rd_en;

    // in_ready depends only on stored state, so a stalled decode never gates fetch combinationally.
    assign empty    = (count_q == '0);
    assign in_ready = (count_q != FULL);
    assign count    = count_q;
    assign push     = in_valid & in_ready;
    assign pop      = out_valid & out_ready;

    // An entry consumed straight through the bypass while empty must not also be stored.
    assign wr_en = push & ~flush & ~(empty & pop);
    assign rd_en = pop & ~flush & ~empty;

    // NOTE: every output gets a default first so no path through this block infers a latch.
    always_comb begin
        out_valid = 1'b0;
        out_pc4   = '0;
        out_inst  = '0;
`ifdef PIPE_IFID_QUEUE_BYPASS_EN
        if (!flush) begin
            if (!empty) begin
                out_valid = 1'b1;
                out_pc4   = pc4_mem_q[rd_ptr_q];
                out_inst  = inst_mem_q[rd_ptr_q];
            end else if (in_valid) begin
                out_valid = 1'b1;
                out_pc4   = in_pc4;
                out_inst  = in_inst;
            end
        end
`else
        if (!empty) begin
            out_valid = 1'b1;
            out_pc4   = pc4_mem_q[rd_ptr_q];
            out_inst  = inst_mem_q[rd_ptr_q];
        end
`endif
    end

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = wr_ptr_q;
            count_d  = '0;
        end else begin
            if (wr_en) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (rd_en) rd_ptr_d = rd_ptr_q + PTR_W'(1);
            case ({wr_en, rd_en})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: storage is deliberately not reset; count gates visibility, so stale words never reach decode.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            pc4_mem_q[wr_ptr_q]  <= in_pc4;
            inst_mem_q[wr_ptr_q] <= in_inst;
        end
    end

endmodule

// File: tb/tb_pipe_ifid_queue.sv
// Directed self-checking bench for pipe_ifid_queue (DATA_W=32, DEPTH=4).
module tb_pipe_ifid_queue;

    logic        clk = 1'b0;
    logic        reset, flush, in_valid, in_ready, out_valid, out_ready;
    logic [31:0] in_pc4, in_inst, out_pc4, out_inst;
    logic [2:0]  count;
    int          errors = 0;
    int          checks = 0;

    pipe_ifid_queue #(.DATA_W(32), .DEPTH(4)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_pc4(in_pc4), .in_inst(in_inst),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc4(out_pc4), .out_inst(out_inst),
        .count(count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_pc4 = '0; in_inst = '0;
    endtask

    task automatic push_stalled(input logic [31:0] pc4, input logic [31:0] inst);
        in_valid = 1'b1; out_ready = 1'b0; in_pc4 = pc4; in_inst = inst;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; idle(); in_valid = 1'b1; in_inst = 32'hDEAD; in_pc4 = 32'h4;
        tick(); tick();
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", count); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        checks++; if (out_inst !== 32'h0) begin errors++; $display("FAIL reset_out_inst got=%h exp=0", out_inst); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        reset = 1'b0; idle();
        tick();
    endtask

    task automatic test_fill_drain();
        for (int i = 0; i < 4; i++) begin
            push_stalled(32'(4 * (i + 1)), 32'h11 + 32'(i));
            checks++; if (out_inst !== 32'h11) begin errors++; $display("FAIL stall_hold_inst[%0d] got=%h exp=11", i, out_inst); end
        end
        checks++; if (count !== 3'd4) begin errors++; $display("FAIL fill_count got=%0d exp=4", count); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL fill_in_ready got=%b exp=0", in_ready); end
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks++; if (out_inst !== 32'h11 + 32'(i)) begin errors++; $display("FAIL drain_inst[%0d] got=%h exp=%h", i, out_inst, 32'h11 + 32'(i)); end
            checks++; if (out_pc4 !== 32'(4 * (i + 1))) begin errors++; $display("FAIL drain_pc4[%0d] got=%h exp=%h", i, out_pc4, 32'(4 * (i + 1))); end
            tick();
        end
        checks++; if (out_inst !== 32'h0 || out_valid !== 1'b0) begin errors++; $display("FAIL drain_empty got=%h/%b exp=0/0", out_inst, out_valid); end
        idle();
    endtask

    task automatic test_wrap();
        in_valid = 1'b1; out_ready = 1'b1; in_inst = 32'h100; in_pc4 = 32'h1000;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL no_bypass_valid got=%b exp=0", out_valid); end
        tick();
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL push_latency_valid got=%b exp=1", out_valid); end
        for (int i = 1; i < 10; i++) begin
            in_inst = 32'h100 + 32'(i); in_pc4 = 32'h1000 + 32'(4 * i);
            checks++; if (out_inst !== 32'h100 + 32'(i - 1)) begin errors++; $display("FAIL wrap_inst[%0d] got=%h exp=%h", i, out_inst, 32'h100 + 32'(i - 1)); end
            tick();
            checks++; if (count !== 3'd1) begin errors++; $display("FAIL wrap_count[%0d] got=%0d exp=1", i, count); end
        end
        in_valid = 1'b0;
        checks++; if (out_inst !== 32'h109) begin errors++; $display("FAIL wrap_last got=%h exp=109", out_inst); end
        tick();
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL wrap_final_count got=%0d exp=0", count); end
        idle();
    endtask

    task automatic test_flush();
        for (int i = 0; i < 3; i++) push_stalled(32'h20 + 32'(4 * i), 32'h21 + 32'(i));
        checks++; if (count !== 3'd3) begin errors++; $display("FAIL flush_pre_count got=%0d exp=3", count); end
        flush = 1'b1; in_valid = 1'b1; out_ready = 1'b1; in_inst = 32'h99; in_pc4 = 32'h90;
        tick();
        idle();
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL flush_count got=%0d exp=0", count); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_out_valid got=%b exp=0", out_valid); end
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++; if (out_valid !== 1'b0 || out_inst === 32'h99) begin errors++; $display("FAIL flush_ghost[%0d] got=%b/%h exp=0/0", i, out_valid, out_inst); end
        end
    endtask

    task automatic test_full_simultaneous();
        for (int i = 0; i < 4; i++) push_stalled(32'h40 + 32'(4 * i), 32'h31 + 32'(i));
        in_valid = 1'b1; out_ready = 1'b1; in_inst = 32'h3F; in_pc4 = 32'h7C;
        tick();
        in_valid = 1'b0;
        checks++; if (count !== 3'd3) begin errors++; $display("FAIL full_sim_count got=%0d exp=3", count); end
        for (int i = 0; i < 3; i++) begin
            checks++; if (out_inst !== 32'h32 + 32'(i)) begin errors++; $display("FAIL full_sim_drain[%0d] got=%h exp=%h", i, out_inst, 32'h32 + 32'(i)); end
            tick();
        end
        checks++; if (out_valid !== 1'b0 || count !== 3'd0) begin errors++; $display("FAIL full_sim_empty got=%b/%0d exp=0/0", out_valid, count); end
        idle();
    endtask

    task automatic test_reset_mid_op();
        for (int i = 0; i < 2; i++) push_stalled(32'h50, 32'h51 + 32'(i));
        reset = 1'b1; flush = 1'b1; in_valid = 1'b1; out_ready = 1'b1; in_inst = 32'h77;
        tick();
        reset = 1'b0; idle();
        checks++; if (count !== 3'd0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL mid_reset got=%0d/%b/%b exp=0/0/1", count, out_valid, in_ready);
        end
    endtask

    task automatic test_bypass();
`ifdef PIPE_IFID_QUEUE_BYPASS_EN
        in_valid = 1'b1; out_ready = 1'b1; in_inst = 32'h2108; in_pc4 = 32'h84;
        #1;
        checks++; if (out_inst !== 32'h2108 || out_valid !== 1'b1) begin errors++; $display("FAIL bypass_same_cycle got=%h/%b exp=2108/1", out_inst, out_valid); end
        tick();
        in_valid = 1'b0;
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL bypass_count got=%0d exp=0", count); end
`else
        in_valid = 1'b1; out_ready = 1'b1; in_inst = 32'h2108; in_pc4 = 32'h84;
        #1;
        checks++; if (out_inst !== 32'h0) begin errors++; $display("FAIL no_bypass_inst got=%h exp=0", out_inst); end
        tick();
        in_valid = 1'b0;
        checks++; if (out_inst !== 32'h2108 || count !== 3'd1) begin errors++; $display("FAIL registered_inst got=%h/%0d exp=2108/1", out_inst, count); end
        tick();
`endif
        idle();
    endtask

    initial begin
        test_reset();
        test_fill_drain();
        test_wrap();
        test_flush();
        test_full_simultaneous();
        test_reset_mid_op();
        test_bypass();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
